// File: rtl/xbar_epoch_sched_pkg.sv
// xbar_pkg: shared constants, port typedefs and scheduler FSM states for xbar_epoch_sched.
package xbar_pkg;
   localparam int N_PORTS_DEFAULT = 4;
   localparam int PORT_W = $clog2(N_PORTS_DEFAULT);
   typedef logic [PORT_W-1:0] port_idx_t;
   typedef logic [N_PORTS_DEFAULT-1:0] port_vec_t;
   typedef enum logic [1:0] {IDLE, GRANT, ACCEPT, HOLD} sched_state_e;
endpackage

// File: rtl/xbar_epoch_sched_if.sv
// xbar_epoch_sched_if: control, VOQ occupancy and match outputs of the epoch scheduler.
// Stat ports exist only when XBAR_SCHED_STATS_EN is defined.
interface xbar_epoch_sched_if #(
   parameter int N_PORTS = xbar_pkg::N_PORTS_DEFAULT,
   parameter int EPOCH_W = 8
);
   localparam int PW = $clog2(N_PORTS);
   logic sched_en;
   logic [EPOCH_W-1:0] epoch_len;
   logic [N_PORTS*N_PORTS-1:0] voq_nonempty;
   logic match_valid;
   logic epoch_start;
   logic [N_PORTS-1:0] match_in_vld;
   logic [N_PORTS*PW-1:0] match_in2out;
   logic busy;
`ifdef XBAR_SCHED_STATS_EN
   logic [PW-1:0] stat_sel;
   logic [31:0] stat_count;
   modport master (output sched_en, epoch_len, voq_nonempty, stat_sel,
                   input match_valid, epoch_start, match_in_vld, match_in2out, busy, stat_count);
   modport slave (input sched_en, epoch_len, voq_nonempty, stat_sel,
                  output match_valid, epoch_start, match_in_vld, match_in2out, busy, stat_count);
`else
   modport master (output sched_en, epoch_len, voq_nonempty,
                   input match_valid, epoch_start, match_in_vld, match_in2out, busy);
   modport slave (input sched_en, epoch_len, voq_nonempty,
                  output match_valid, epoch_start, match_in_vld, match_in2out, busy);
`endif
endinterface

// File: rtl/xbar_epoch_sched_rr_pick.sv
// rr_pick: round-robin arbiter, first set request found cyclically from ptr.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);
   localparam int PW = $clog2(N);
   // scan farthest first so the candidate closest to ptr overwrites the rest
   always_comb begin
      idx = '0;
      found = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[ptr + PW'(k)]) begin
            idx = ptr + PW'(k);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/xbar_epoch_sched.sv
// xbar_epoch_sched: one-iteration iSLIP crossbar scheduler holding each match for an epoch.
// Define XBAR_SCHED_STATS_EN to add per-egress match counters read through stat_sel/stat_count.
module xbar_epoch_sched
   import xbar_pkg::*;
#(
   parameter int N_PORTS = N_PORTS_DEFAULT,
   parameter int EPOCH_W = 8
) (
   input logic clk,
   input logic reset,
   xbar_epoch_sched_if.slave bus
);
   localparam int PW = $clog2(N_PORTS);
   sched_state_e state;
   logic [N_PORTS*N_PORTS-1:0] req_snap;
   logic [N_PORTS-1:0][PW-1:0] g_ptr, a_ptr, g_idx, g_idx_c, acc_idx;
   logic [N_PORTS-1:0] g_vld, g_vld_c, acc_found;
   logic [EPOCH_W-1:0] hold_cnt;
   logic [N_PORTS*PW-1:0] m2o_nxt;
   for (genvar j = 0; j < N_PORTS; j++) begin : g_grant
      logic [N_PORTS-1:0] col;
      always_comb for (int i = 0; i < N_PORTS; i++) col[i] = req_snap[i*N_PORTS+j];
      rr_pick #(.N(N_PORTS)) u_pick (.req(col), .ptr(g_ptr[j]), .idx(g_idx_c[j]), .found(g_vld_c[j]));
   end
   for (genvar i = 0; i < N_PORTS; i++) begin : g_accept
      logic [N_PORTS-1:0] row;
      always_comb for (int j = 0; j < N_PORTS; j++) row[j] = g_vld[j] && (g_idx[j] == PW'(i));
      rr_pick #(.N(N_PORTS)) u_pick (.req(row), .ptr(a_ptr[i]), .idx(acc_idx[i]), .found(acc_found[i]));
   end
   always_comb begin
      m2o_nxt = '0;
      for (int i = 0; i < N_PORTS; i++) m2o_nxt[i*PW +: PW] = acc_found[i] ? acc_idx[i] : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         req_snap <= '0;
         g_ptr <= '0;
         a_ptr <= '0;
         g_vld <= '0;
         g_idx <= '0;
         hold_cnt <= '0;
         bus.match_valid <= 1'b0;
         bus.epoch_start <= 1'b0;
         bus.match_in_vld <= '0;
         bus.match_in2out <= '0;
         bus.busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.sched_en) begin
               req_snap <= bus.voq_nonempty;
               bus.busy <= 1'b1;
               state <= GRANT;
            end
            GRANT: begin
               g_vld <= g_vld_c;
               g_idx <= g_idx_c;
               state <= ACCEPT;
            end
            ACCEPT: begin
               bus.match_in_vld <= acc_found;
               bus.match_in2out <= m2o_nxt;
               bus.match_valid <= 1'b1;
               bus.epoch_start <= 1'b1;
               hold_cnt <= (bus.epoch_len == '0) ? EPOCH_W'(1) : bus.epoch_len;
               // each egress grants one ingress, so at most one accepted pair touches g_ptr[j]
               for (int i = 0; i < N_PORTS; i++) begin
                  if (acc_found[i]) begin
                     a_ptr[i] <= acc_idx[i] + PW'(1);
                     g_ptr[acc_idx[i]] <= PW'(i + 1);
                  end
               end
               state <= HOLD;
            end
            HOLD: begin
               bus.epoch_start <= 1'b0;
               hold_cnt <= hold_cnt - EPOCH_W'(1);
               if (hold_cnt == EPOCH_W'(1)) begin
                  bus.match_valid <= 1'b0;
                  bus.match_in_vld <= '0;
                  bus.match_in2out <= '0;
                  bus.busy <= bus.sched_en;
                  req_snap <= bus.sched_en ? bus.voq_nonempty : req_snap;
                  state <= bus.sched_en ? GRANT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef XBAR_SCHED_STATS_EN
   logic [N_PORTS-1:0] out_hit;
   logic [31:0] stat_cnt [N_PORTS];
   always_comb begin
      out_hit = '0;
      for (int i = 0; i < N_PORTS; i++) if (acc_found[i]) out_hit[acc_idx[i]] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < N_PORTS; j++) stat_cnt[j] <= '0;
         bus.stat_count <= '0;
      end else begin
         for (int j = 0; j < N_PORTS; j++)
            if (state == ACCEPT && out_hit[j] && stat_cnt[j] != '1) stat_cnt[j] <= stat_cnt[j] + 32'd1;
         bus.stat_count <= stat_cnt[bus.stat_sel];
      end
   end
`endif
endmodule
